// File: rtl/cp0_regfile_if.sv
// Commit-stage bus between the pipeline and the CP0 register file:
// WB request, MFC0 read port and the redirect/flush/timer results.
interface cp0_regfile_if;
    logic        wb_valid;
    logic [2:0]  wb_cp0Op;
    logic [4:0]  wb_cs;
    logic [2:0]  wb_sel;
    logic [31:0] wb_wdata;
    logic [31:0] wb_pc;
    logic [4:0]  rd_cs;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic [31:0] epc_out;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        timer_irq;

    modport master (
        output wb_valid, wb_cp0Op, wb_cs, wb_sel, wb_wdata, wb_pc, rd_cs, rd_sel,
        input  rd_data, epc_out, redirect, redirect_pc, flush, timer_irq
    );

    modport slave (
        input  wb_valid, wb_cp0Op, wb_cs, wb_sel, wb_wdata, wb_pc, rd_cs, rd_sel,
        output rd_data, epc_out, redirect, redirect_pc, flush, timer_irq
    );
endinterface

// File: rtl/cp0_regfile.sv
// Architectural CP0 state (Count, Compare, Status, Cause, EPC) updated at commit;
// decides SYSCALL / ERET / timer-interrupt redirects combinationally from WB.
module cp0_regfile #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0800,
    parameter logic [4:0]  SYSCALL_CODE = 5'd8,
    parameter logic [4:0]  INT_CODE     = 5'd0
) (
    input  logic           clk,
    input  logic           rst_n,
    cp0_regfile_if.slave   bus
);
    localparam logic [2:0] OP_MTC0    = 3'b010;
    localparam logic [2:0] OP_SYSCALL = 3'b011;
    localparam logic [2:0] OP_ERET    = 3'b100;

    localparam logic [4:0] CS_COUNT   = 5'd9;
    localparam logic [4:0] CS_COMPARE = 5'd11;
    localparam logic [4:0] CS_STATUS  = 5'd12;
    localparam logic [4:0] CS_CAUSE   = 5'd13;
    localparam logic [4:0] CS_EPC     = 5'd14;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        ip7_q, ip7_d;
    logic [31:0] epc_q, epc_d;

    logic take_sys, take_eret, take_int, do_mtc0;

    always_comb begin
        take_sys  = bus.wb_valid && (bus.wb_cp0Op == OP_SYSCALL);
        take_eret = bus.wb_valid && (bus.wb_cp0Op == OP_ERET);
        // An interrupt squashes the committing instruction, including any MTC0 it carries.
        take_int  = bus.wb_valid && ie_q && !exl_q && ip7_q && !take_sys && !take_eret;
        do_mtc0   = bus.wb_valid && (bus.wb_cp0Op == OP_MTC0) && !take_int
                    && (bus.wb_sel == 3'd0);
    end

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ie_d      = ie_q;
        exl_d     = exl_q;
        exccode_d = exccode_q;
        ip7_d     = ip7_q | (count_q == compare_q);
        epc_d     = epc_q;

        if (take_sys) begin
            if (!exl_q) begin
                epc_d     = bus.wb_pc;
                exccode_d = SYSCALL_CODE;
                exl_d     = 1'b1;
            end
        end else if (take_eret) begin
            exl_d = 1'b0;
        end else if (take_int) begin
            epc_d     = bus.wb_pc;
            exccode_d = INT_CODE;
            exl_d     = 1'b1;
        end else if (do_mtc0) begin
            // Writes to Count/Compare override this cycle's increment and match.
            case (bus.wb_cs)
                CS_COUNT: begin
                    count_d = bus.wb_wdata;
                    ip7_d   = ip7_q;
                end
                CS_COMPARE: begin
                    compare_d = bus.wb_wdata;
                    ip7_d     = 1'b0;
                end
                CS_STATUS: begin
                    ie_d  = bus.wb_wdata[0];
                    exl_d = bus.wb_wdata[1];
                end
                CS_CAUSE: exccode_d = bus.wb_wdata[6:2];
                CS_EPC:   epc_d     = bus.wb_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            exccode_q <= 5'd0;
            ip7_q     <= 1'b0;
            epc_q     <= 32'd0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            exccode_q <= exccode_d;
            ip7_q     <= ip7_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        bus.rd_data = 32'd0;
        if (bus.rd_sel == 3'd0) begin
            case (bus.rd_cs)
                CS_COUNT:   bus.rd_data = count_q;
                CS_COMPARE: bus.rd_data = compare_q;
                CS_STATUS:  bus.rd_data = {30'd0, exl_q, ie_q};
                CS_CAUSE:   bus.rd_data = {16'd0, ip7_q, 8'd0, exccode_q, 2'd0};
                CS_EPC:     bus.rd_data = epc_q;
                default:    bus.rd_data = 32'd0;
            endcase
        end
    end

    always_comb begin
        bus.redirect    = take_sys || take_eret || take_int;
        bus.redirect_pc = 32'd0;
        if (take_sys || take_int)
            bus.redirect_pc = EXC_VECTOR;
        else if (take_eret)
            bus.redirect_pc = epc_q;
        bus.flush     = bus.redirect;
        bus.timer_irq = ip7_q;
        bus.epc_out   = epc_q;
    end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Architectural CP0 register file for the 5-stage MIPS pipeline, written at WB/commit.
- Holds Count, Compare, Status, Cause and EPC.
- Executes the committed-stage effects of MTC0, SYSCALL, ERET and timer interrupt, and drives the PC redirect/flush.
- Supplies MFC0 read data, and the EPC value used by ERET in ID when no EX/MEM forwarding applies.

Parameters:
- EXC_VECTOR, 32'h0000_0800, handler entry PC for SYSCALL and interrupt.
- SYSCALL_CODE, 5'd8, Cause.ExcCode value for SYSCALL.
- INT_CODE, 5'd0, Cause.ExcCode value for interrupt.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wb_valid  input  1  committed-stage instruction is valid this cycle.
- wb_cp0Op  input  3  000 none, 001 MFC0, 010 MTC0, 011 SYSCALL, 100 ERET.
- wb_cs  input  5  MTC0 destination register number.
- wb_sel  input  3  MTC0 destination select.
- wb_wdata  input  32  MTC0 write data.
- wb_pc  input  32  PC of the committed instruction.
- rd_cs  input  5  MFC0 read register number.
- rd_sel  input  3  MFC0 read select.
- rd_data  output  32  combinational read of the addressed register; 0 for unmapped addresses.
- epc_out  output  32  current EPC register value.
- redirect  output  1  taking exception/ERET this cycle (combinational).
- redirect_pc  output  32  target PC when redirect=1, else 0.
- flush  output  1  equals redirect; flushes IF/ID/EX/MEM.
- timer_irq  output  1  Cause.IP7 (timer pending).

Behaviour:
- Register map, sel=0 for all:
  - cs9 Count.
  - cs11 Compare.
  - cs12 Status: bit0 IE, bit1 EXL, other bits read 0.
  - cs13 Cause: bits[6:2] ExcCode, bit15 IP7, other bits read 0.
  - cs14 EPC.
- Reset (async, rst_n=0):
  - Count=0, Compare=32'hFFFF_FFFF, Status=0, Cause=0, EPC=0.
  - Outputs: redirect=0, flush=0, redirect_pc=0, timer_irq=0, epc_out=0, rd_data reflects the reset registers.
- Count increments by 1 every cycle, wrapping FFFF_FFFF->0.
- IP7 set when Count==Compare at the clock edge; it stays set until an MTC0 to Compare.
- MTC0 writes to Compare or Count take priority over that cycle's increment/match.
- Status and Cause are writable only in the bits defined above.
- The take decision is combinational on the current register state and WB inputs. All state updates occur at the next rising edge. Priority, highest first:
  1. SYSCALL (wb_valid & cp0Op=011):
     - redirect=1, redirect_pc=EXC_VECTOR.
     - If EXL=0: EPC<=wb_pc, ExcCode<=SYSCALL_CODE, EXL<=1.
     - If EXL=1: EPC and ExcCode unchanged, redirect still asserted.
  2. ERET (wb_valid & cp0Op=100):
     - redirect=1, redirect_pc=EPC (current value), EXL<=0.
  3. Interrupt (wb_valid & IE & ~EXL & IP7 & op not SYSCALL/ERET):
     - redirect=1, redirect_pc=EXC_VECTOR.
     - EPC<=wb_pc; the instruction is squashed and its MTC0, if any, is dropped.
     - ExcCode<=INT_CODE, EXL<=1.
  4. MTC0 (wb_valid & cp0Op=010): register write at edge, no redirect.
- wb_valid=0: no redirect, no writes; Count still runs.
- MTC0 to EPC followed by ERET next cycle: ERET uses the newly written EPC (no bypass needed; the register is already updated).
- Interrupt blocked while EXL=1; taken on the first valid instruction after ERET clears EXL, provided IP7 is still set.
- Reset asserted mid-exception clears EXL and all state immediately.
- Unmapped MTC0 addresses are ignored.

Test Plan:
1. Reset, then 5 idle cycles -> Count=5, rd_data(cs9)=5, redirect=0, Status=0.
2. SYSCALL at wb_pc=0x0000_0040 -> same cycle: redirect=1, redirect_pc=0x800; next cycle: EPC=0x40, Cause[6:2]=8, Status.EXL=1.
3. MTC0 cs14=0x0000_0100, then ERET -> ERET cycle: redirect_pc=0x100; afterwards EXL=0.
4. Second SYSCALL while EXL=1 at pc=0x80 -> redirect=1 to 0x800, EPC keeps its prior value.
5. Status.IE=1, Compare=10 -> IP7=1 when Count reaches 10; next valid instruction pc=0x60 -> redirect to 0x800, EPC=0x60, ExcCode=0. MTC0 Compare=50 -> IP7=0.
6. rst_n pulsed low with EXL=1 and IP7=1 -> all registers at reset values immediately, without waiting for clk; timer_irq=0.
